// File: rtl/diff_pkg.sv
// Shared widths and state encoding for the serial front end of the nibble comparator.
package diff_pkg;

    localparam int NIB_W     = 4;
    localparam int NIBBLES   = 4;
    localparam int WORD_W    = NIB_W * NIBBLES;
    localparam int NIB_CNT_W = $clog2(NIBBLES);
    localparam int CNT_W     = $clog2(NIBBLES + 1);
    localparam int IDX_W     = $clog2(NIBBLES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        SETTLE,
        DONE
    } state_t;

endpackage

// File: rtl/diff_result_enc.sv
// Combinational summary of the comparator flags: popcount, all-equal and
// index of the most significant mismatching nibble.
module diff_result_enc
    import diff_pkg::*;
(
    input  logic [NIBBLES-1:0] d,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               all_eq,
    output logic [IDX_W-1:0]   first_diff
);

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            match_cnt = match_cnt + CNT_W'(d[i]);
        end
    end

    assign all_eq = &d;

    // Ascending scan so the highest mismatching index is the last one written.
    always_comb begin
        first_diff = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (!d[i]) begin
                first_diff = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/diff_load_ctrl.sv
// Loads A and B serially (MSB nibble first), holds them while the external
// comparator settles, then captures and holds the summarised result until acked.
module diff_load_ctrl
    import diff_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NIB_W-1:0]   nib_in,
    input  logic               nib_valid,
    output logic               nib_ready,
    output logic [WORD_W-1:0]  A,
    output logic [WORD_W-1:0]  B,
    input  logic [NIBBLES-1:0] d,
    output logic               res_valid,
    input  logic               res_ack,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               all_eq,
    output logic [IDX_W-1:0]   first_diff,
    output logic               busy
);

    // A zero settle time still needs one cycle for the comparator to see A/B.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int SET_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_EFF - 1);
    localparam logic [NIB_CNT_W-1:0] NIB_LAST    = NIB_CNT_W'(NIBBLES - 1);

    state_t                state_reg, state_next;
    logic [WORD_W-1:0]     a_reg, a_next;
    logic [WORD_W-1:0]     b_reg, b_next;
    logic [NIB_CNT_W-1:0]  nib_cnt_reg, nib_cnt_next;
    logic [SET_W-1:0]      settle_cnt_reg, settle_cnt_next;
    logic [CNT_W-1:0]      match_cnt_reg, match_cnt_next;
    logic                  all_eq_reg, all_eq_next;
    logic [IDX_W-1:0]      first_diff_reg, first_diff_next;
    logic                  res_valid_reg, res_valid_next;

    logic [CNT_W-1:0]      enc_match_cnt;
    logic                  enc_all_eq;
    logic [IDX_W-1:0]      enc_first_diff;

    diff_result_enc u_enc (
        .d          (d),
        .match_cnt  (enc_match_cnt),
        .all_eq     (enc_all_eq),
        .first_diff (enc_first_diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            nib_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
            match_cnt_reg  <= '0;
            all_eq_reg     <= 1'b0;
            first_diff_reg <= '0;
            res_valid_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            nib_cnt_reg    <= nib_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            match_cnt_reg  <= match_cnt_next;
            all_eq_reg     <= all_eq_next;
            first_diff_reg <= first_diff_next;
            res_valid_reg  <= res_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        nib_cnt_next    = nib_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        match_cnt_next  = match_cnt_reg;
        all_eq_next     = all_eq_reg;
        first_diff_next = first_diff_reg;
        res_valid_next  = res_valid_reg;
        nib_ready       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = LOAD_A;
                    a_next       = '0;
                    b_next       = '0;
                    nib_cnt_next = '0;
                end
            end
            LOAD_A: begin
                nib_ready = 1'b1;
                if (nib_valid) begin
                    a_next = {a_reg[WORD_W-NIB_W-1:0], nib_in};
                    if (nib_cnt_reg == NIB_LAST) begin
                        state_next   = LOAD_B;
                        nib_cnt_next = '0;
                    end else begin
                        nib_cnt_next = nib_cnt_reg + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                nib_ready = 1'b1;
                if (nib_valid) begin
                    b_next = {b_reg[WORD_W-NIB_W-1:0], nib_in};
                    if (nib_cnt_reg == NIB_LAST) begin
                        state_next      = SETTLE;
                        nib_cnt_next    = '0;
                        settle_cnt_next = '0;
                    end else begin
                        nib_cnt_next = nib_cnt_reg + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next      = DONE;
                    match_cnt_next  = enc_match_cnt;
                    all_eq_next     = enc_all_eq;
                    first_diff_next = enc_first_diff;
                    res_valid_next  = 1'b1;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (res_ack) begin
                    state_next     = IDLE;
                    res_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign A          = a_reg;
    assign B          = b_reg;
    assign match_cnt  = match_cnt_reg;
    assign all_eq     = all_eq_reg;
    assign first_diff = first_diff_reg;
    assign res_valid  = res_valid_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_diff_load_ctrl.sv
// Randomised bench for diff_load_ctrl; the bench also plays the role of the
// nibble comparator and predicts results from the operands it sends.
module tb_diff_load_ctrl;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        nib_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  d;
    logic        res_valid;
    logic        res_ack;
    logic [2:0]  match_cnt;
    logic        all_eq;
    logic [1:0]  first_diff;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    diff_load_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nib_in     (nib_in),
        .nib_valid  (nib_valid),
        .nib_ready  (nib_ready),
        .A          (A),
        .B          (B),
        .d          (d),
        .res_valid  (res_valid),
        .res_ack    (res_ack),
        .match_cnt  (match_cnt),
        .all_eq     (all_eq),
        .first_diff (first_diff),
        .busy       (busy)
    );

    function automatic logic [3:0] comparator(input logic [15:0] x, input logic [15:0] y);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (x[4*k +: 4] == y[4*k +: 4]);
        return r;
    endfunction

    assign d = comparator(A, B);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_matches(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        for (int k = 0; k < 4; k++) if (((a >> (4*k)) & 16'hF) == ((b >> (4*k)) & 16'hF)) n++;
        return n;
    endfunction

    function automatic int model_first_diff(input logic [15:0] a, input logic [15:0] b);
        for (int k = 3; k >= 0; k--) if (((a >> (4*k)) & 16'hF) != ((b >> (4*k)) & 16'hF)) return k;
        return 0;
    endfunction

    // Partial register contents after n of 4 MSB-first nibbles have been shifted in.
    function automatic logic [15:0] partial(input logic [15:0] w, input int n);
        return w >> (4 * (4 - n));
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_A"}, A, 0);
        check({tag, "_B"}, B, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rv"}, res_valid, 0);
        check({tag, "_rdy"}, nib_ready, 0);
        check({tag, "_mc"}, match_cnt, 0);
        check({tag, "_eq"}, all_eq, 0);
        check({tag, "_fd"}, first_diff, 0);
    endtask

    // One comparison: gap2/gap6 stall cycles after the 2nd/6th nibble,
    // hold = cycles in DONE before ack, abort = reset in 2nd SETTLE cycle.
    task automatic run_cmp(input logic [15:0] a, input logic [15:0] b,
                           input int gap2, input int gap6, input int hold, input bit abort);
        int edges;
        int exp_mc;
        int exp_fd;
        logic [15:0] ea;
        logic [15:0] eb;
        exp_mc = model_matches(a, b);
        exp_fd = model_first_diff(a, b);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        check("busy_load", busy, 1);
        check("a_clear", A, 0);
        check("b_clear", B, 0);

        for (int i = 0; i < 8; i++) begin
            check("rdy_load", nib_ready, 1);
            nib_valid = 1'b1;
            nib_in = (i < 4) ? 4'((a >> (12 - 4*i)) & 16'hF) : 4'((b >> (12 - 4*(i-4))) & 16'hF);
            @(negedge clk);
            edges++;
            nib_valid = 1'b0;
            if (i == 1 || i == 5) begin
                ea = (i == 1) ? partial(a, 2) : a;
                eb = (i == 1) ? 16'h0 : partial(b, 2);
                for (int g = 0; g < ((i == 1) ? gap2 : gap6); g++) begin
                    nib_in = 4'($urandom_range(0, 15));
                    @(negedge clk);
                    edges++;
                    check("gap_A", A, ea);
                    check("gap_B", B, eb);
                    check("gap_rdy", nib_ready, 1);
                end
            end
        end
        check("loaded_A", A, a);
        check("loaded_B", B, b);
        check("settle_rdy", nib_ready, 0);

        if (abort) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            check_reset_state("abort");
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < S + 3; c++) begin
                @(negedge clk);
                check("abort_no_rv", res_valid, 0);
            end
            check("abort_idle", busy, 0);
            return;
        end

        while (!res_valid && edges < 200) begin
            nib_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            edges++;
        end
        nib_valid = 1'b0;
        check("res_valid", res_valid, 1);
        check("latency", edges, 1 + 8 + gap2 + gap6 + S);
        check("match_cnt", match_cnt, exp_mc);
        check("all_eq", all_eq, (exp_mc == 4) ? 1 : 0);
        check("first_diff", first_diff, exp_fd);

        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom_range(0, 1));
            nib_valid = 1'($urandom_range(0, 1));
            nib_in = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("hold_rv", res_valid, 1);
            check("hold_rdy", nib_ready, 0);
            check("hold_A", A, a);
            check("hold_B", B, b);
            check("hold_mc", match_cnt, exp_mc);
            check("hold_fd", first_diff, exp_fd);
        end
        res_ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        start = 1'b0;
        nib_valid = 1'b0;
        check("ack_rv", res_valid, 0);
        check("ack_idle", busy, 0);
        check("ack_keep_mc", match_cnt, exp_mc);
        check("ack_keep_fd", first_diff, exp_fd);
        $display("cmp A=%h B=%h gaps=%0d/%0d hold=%0d mc=%0d fd=%0d", a, b, gap2, gap6, hold, exp_mc, exp_fd);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst = 1'b1;
        start = 1'b0;
        nib_in = 4'h0;
        nib_valid = 1'b0;
        res_ack = 1'b0;
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run_cmp(16'h1234, 16'h1234, 0, 0, 1, 1'b0);
        run_cmp(16'h1234, 16'h1235, 0, 0, 1, 1'b0);
        run_cmp(16'hABCD, 16'h0BCD, 0, 0, 0, 1'b0);
        run_cmp(16'hFFFF, 16'h0000, 0, 0, 0, 1'b0);
        run_cmp(16'h1234, 16'h1235, 3, 3, 0, 1'b0);
        run_cmp(16'h5A5A, 16'h5A5B, 0, 0, 0, 1'b1);
        run_cmp(16'h9876, 16'h1876, 0, 0, 10, 1'b0);

        for (int t = 0; t < 25; t++) begin
            ra = 16'($urandom);
            rb = ra;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) rb[4*k +: 4] = 4'($urandom);
            end
            run_cmp(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/diff_load_ctrl.md
Name: diff_load_ctrl

Overview:
- Sequential front/back end for the 4-nibble equality comparator `diff`: A[15:0], B[15:0] in; d[3:0] out, d[k]=1 when nibble k of A equals nibble k of B.
- Receives A and B serially as 4-bit nibbles over a valid/ready handshake and drives them onto the comparator.
- Waits a programmable settle time to cover the comparator's gate delays, then captures d.
- Reports match count, all-equal flag and index of the most significant mismatching nibble; holds the result until acknowledged.

Parameters:
- SETTLE_CYCLES, 4, cycles A/B are held stable before d is sampled; a value of 0 is treated as 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new comparison; honoured only in IDLE
- nib_in  in  4  serial operand nibble
- nib_valid  in  1  nib_in valid
- nib_ready  out  1  block accepts a nibble this cycle
- A  out  16  operand A to comparator
- B  out  16  operand B to comparator
- d  in  4  per-nibble equality flags from comparator
- res_valid  out  1  result fields valid
- res_ack  in  1  consumer takes the result
- match_cnt  out  3  number of set bits in captured d (0..4)
- all_eq  out  1  captured d == 4'hF
- first_diff  out  2  highest k with d[k]==0; 0 when all_eq
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state IDLE; A, B, match_cnt, first_diff = 0; all_eq, res_valid, nib_ready, busy = 0; nibble and settle counters = 0. Reset in any state, including mid-load or mid-settle, aborts the operation. No partial result is produced.
- States: IDLE, LOAD_A, LOAD_B, SETTLE, DONE.
- IDLE:
  - start=1 -> LOAD_A next cycle.
  - A, B cleared to 0 on that same edge.
  - Nibble counter cleared to 0.
- LOAD_A:
  - nib_ready=1; a transfer occurs on nib_valid & nib_ready.
  - Each transfer: A <= {A[11:0], nib_in}, so the first nibble sent ends up in A[15:12] (MSB first). Nibble counter +1.
  - On the 4th transfer -> LOAD_B, counter reset to 0.
  - No transfer (nib_valid low) = stall; state and registers hold.
- LOAD_B: identical to LOAD_A, shifting into B. On the 4th transfer -> SETTLE, settle counter loaded with 0.
- SETTLE:
  - nib_ready=0; A and B held constant.
  - Counter increments each cycle.
  - On the edge ending the SETTLE_CYCLES-th cycle in SETTLE:
    - d is sampled.
    - match_cnt, all_eq and first_diff are registered from that sample.
    - res_valid <= 1; state -> DONE.
- DONE:
  - Outputs held; A and B still held.
  - res_ack=1 -> IDLE next edge, res_valid <= 0. Result fields keep their values until overwritten by the next capture.
- start is ignored outside IDLE, including in DONE, even in the same cycle as res_ack.
- nib_valid outside LOAD_A/LOAD_B is ignored; nib_ready is 0 there.
- Latency: with no stalls, start-to-res_valid = 1 + 8 + SETTLE_CYCLES cycles.
- Timing: the comparator settles in about 100 ns, so clk period × SETTLE_CYCLES must be at least 100 ns. This is the integrator's responsibility.
- Widths: match_cnt is a 3-bit popcount of a 4-bit value. first_diff uses a priority encoder over ~d, highest index wins.

Decomposition:
- Package diff_pkg:
  - NIB_W=4, NIBBLES=4, WORD_W=16.
  - State enum (IDLE, LOAD_A, LOAD_B, SETTLE, DONE).
  - Counter width constants.
- Sub-module diff_result_enc (combinational): d in; match_cnt, all_eq, first_diff out. Instantiated once; its outputs are registered in diff_load_ctrl.

Test Plan:
- Send nibbles 1,2,3,4 then 1,2,3,4 (A=B=0x1234); comparator returns d=4'hF -> match_cnt=4, all_eq=1, first_diff=0, res_valid 13 cycles after start (SETTLE_CYCLES=4, no stalls).
- A=0x1234, B=0x1235, d=4'b1110 -> match_cnt=3, all_eq=0, first_diff=0.
- A=0xABCD, B=0x0BCD, d=4'b0111 -> match_cnt=3, first_diff=3. Also A=0xFFFF, B=0x0000, d=0 -> match_cnt=0, first_diff=3.
- Drop nib_valid for 3 cycles after the 2nd and 6th nibbles -> A/B unchanged during gaps, counters hold; final A=0x1234, B=0x1235; res_valid delayed by exactly 6 cycles.
- Assert rst for 1 cycle in the 2nd SETTLE cycle -> all outputs 0 immediately, state IDLE, no res_valid. A following start with fresh operands completes normally.
- Hold res_ack=0 for 10 cycles in DONE while pulsing start and nib_valid -> result and A/B stable, nib_ready=0. res_ack=1 -> IDLE, res_valid=0 next edge.
